// File: rtl/audio_frame_sequencer_if.sv
// Request/acknowledge channel between the frame sequencer (master) and the
// shared sample-processing engine (slave).
interface audio_frame_sequencer_if #(
  parameter int DataWidth = 12
);
  logic                 procReq;
  logic [DataWidth-1:0] procData;
  logic                 procAck;
  logic [DataWidth-1:0] procResult;

  modport master (output procReq, output procData, input procAck, input procResult);
  modport slave  (input procReq, input procData, output procAck, output procResult);
endinterface

// File: rtl/audio_frame_sequencer.sv
// Per-frame sequencer: issues each ADC sample to the shared engine, applies a
// soft-mute gain ramp on the way to the DAC and falls back to the dry sample on deadline miss.
module audio_frame_sequencer #(
  parameter int DataWidth    = 12,
  parameter int TimeoutWidth = 10,
  parameter int GainShift    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [DataWidth-1:0] adcData,
  input  logic                        adcDataValid,
  input  logic [TimeoutWidth-1:0]     timeout,
  input  logic                        bypass,
  input  logic                        muteReq,
  audio_frame_sequencer_if.master     eng,
  output logic signed [DataWidth-1:0] dacData,
  output logic                        dacDataValid,
  output logic [7:0]                  underrunCount,
  output logic [7:0]                  overrunCount,
  output logic                        busy
);

  localparam int GainWidth = GainShift + 1;
  localparam int ProdWidth = DataWidth + GainWidth + 1;
  localparam logic [GainWidth-1:0]    GainZero  = GainWidth'(0);
  localparam logic [GainWidth-1:0]    GainOne   = GainWidth'(1);
  localparam logic [GainWidth-1:0]    GainUnity = GainWidth'(1) << GainShift;
  localparam logic [TimeoutWidth-1:0] TimerOne  = TimeoutWidth'(1);
  localparam logic [7:0]              CntMax    = 8'hFF;
  localparam logic [7:0]              CntOne    = 8'h01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    EMIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic                     adc_valid_q, adc_valid_d;
  logic                     proc_req_q, proc_req_d;
  logic [DataWidth-1:0]     proc_data_q, proc_data_d;
  logic [DataWidth-1:0]     result_q, result_d;
  logic [TimeoutWidth-1:0]  timer_q, timer_d;
  logic [TimeoutWidth-1:0]  timeout_q, timeout_d;
  logic                     abandoned_q, abandoned_d;
  logic [GainWidth-1:0]     gain_q, gain_d;
  logic [DataWidth-1:0]     dac_data_q, dac_data_d;
  logic                     dac_valid_q, dac_valid_d;
  logic [7:0]               underrun_q, underrun_d;
  logic [7:0]               overrun_q, overrun_d;
  logic                     busy_q, busy_d;
  logic                     strobe_s;

  logic signed [ProdWidth-1:0] res_ext_s, gain_ext_s, prod_s;
  logic                        unused_prod_s;

  // Full-width signed product; taking bits above GainShift is the floor shift.
  assign res_ext_s     = {{(ProdWidth-DataWidth){result_q[DataWidth-1]}}, result_q};
  assign gain_ext_s    = {{(ProdWidth-GainWidth){1'b0}}, gain_q};
  assign prod_s        = res_ext_s * gain_ext_s;
  assign unused_prod_s = ^{prod_s[ProdWidth-1:DataWidth+GainShift], prod_s[GainShift-1:0]};
  assign strobe_s      = adcDataValid & ~adc_valid_q;

  always_comb begin
    state_d     = state_q;
    adc_valid_d = adcDataValid;
    proc_data_d = proc_data_q;
    result_d    = result_q;
    timer_d     = timer_q;
    timeout_d   = timeout_q;
    abandoned_d = abandoned_q;
    gain_d      = gain_q;
    dac_data_d  = dac_data_q;
    dac_valid_d = 1'b0;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (strobe_s) begin
          proc_data_d = adcData;
          timeout_d   = timeout;
          timer_d     = '0;
          if (bypass) begin
            result_d = adcData;
            state_d  = EMIT;
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (eng.procAck) begin
          result_d = eng.procResult;
          state_d  = EMIT;
        end else if (timer_q == timeout_q) begin
          result_d    = proc_data_q;
          abandoned_d = 1'b1;
          underrun_d  = (underrun_q == CntMax) ? underrun_q : underrun_q + CntOne;
          state_d     = EMIT;
        end else begin
          timer_d = timer_q + TimerOne;
        end
      end
      EMIT: begin
        dac_data_d  = prod_s[DataWidth+GainShift-1:GainShift];
        dac_valid_d = 1'b1;
        if (muteReq && (gain_q != GainZero)) begin
          gain_d = gain_q - GainOne;
        end else if (!muteReq && (gain_q < GainUnity)) begin
          gain_d = gain_q + GainOne;
        end else begin
          gain_d = gain_q;
        end
        // procReq is still raised here after an abandon, so a late ack may land now.
        if (abandoned_q && eng.procAck) begin
          abandoned_d = 1'b0;
          state_d     = IDLE;
        end else if (abandoned_q) begin
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (eng.procAck) begin
          abandoned_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (strobe_s && (state_q != IDLE)) begin
      overrun_d = (overrun_q == CntMax) ? overrun_q : overrun_q + CntOne;
    end else begin
      overrun_d = overrun_d;
    end

    proc_req_d = (state_d == REQ) || (state_d == DRAIN) || ((state_d == EMIT) && abandoned_d);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      adc_valid_q <= 1'b0;
      proc_req_q  <= 1'b0;
      proc_data_q <= '0;
      result_q    <= '0;
      timer_q     <= '0;
      timeout_q   <= '0;
      abandoned_q <= 1'b0;
      gain_q      <= '0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      underrun_q  <= 8'h00;
      overrun_q   <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      adc_valid_q <= adc_valid_d;
      proc_req_q  <= proc_req_d;
      proc_data_q <= proc_data_d;
      result_q    <= result_d;
      timer_q     <= timer_d;
      timeout_q   <= timeout_d;
      abandoned_q <= abandoned_d;
      gain_q      <= gain_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign eng.procReq   = proc_req_q;
  assign eng.procData  = proc_data_q;
  assign dacData       = dac_data_q;
  assign dacDataValid  = dac_valid_q;
  assign underrunCount = underrun_q;
  assign overrunCount  = overrun_q;
  assign busy          = busy_q;

endmodule

// File: doc/audio_frame_sequencer.md
Name: audio_frame_sequencer

Overview:
Per-frame sequencer between the I2S controller and a shared sample-processing engine. It detects each new ADC sample and issues it to the engine over a req/ack handshake. The result goes back to the DAC port with a soft-mute gain ramp applied. If the engine misses a programmable deadline, the block outputs the dry sample instead and counts the event.

Parameters:
- DataWidth, 12: sample width, signed two's complement.
- TimeoutWidth, 10: width of the deadline configuration input.
- GainShift, 4: gain resolution. Gain range is 0..2^GainShift, where 2^GainShift is unity.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- adcData  in  DataWidth  signed sample from the I2S controller.
- adcDataValid  in  1  high for one or more cycles after each frame. Only its rising edge is meaningful.
- timeout  in  TimeoutWidth  engine deadline, in cycles spent in REQ beyond the first.
- bypass  in  1  when 1, skip the engine and use the dry sample.
- muteReq  in  1  when 1, gain ramps toward 0; when 0, gain ramps toward unity.
- procReq  out  1  request to the shared engine.
- procData  out  DataWidth  sample offered to the engine. Stable while procReq=1.
- procAck  in  1  engine accepts the request; procResult is valid in the same cycle.
- procResult  in  DataWidth  signed engine output.
- dacData  out  DataWidth  signed sample to the I2S controller.
- dacDataValid  out  1  one-cycle pulse when dacData is updated.
- underrunCount  out  8  saturating count of deadline misses.
- overrunCount  out  8  saturating count of samples dropped because the block was busy.
- busy  out  1  1 whenever state is not IDLE.

Behaviour:
- Strobe definition:
  - strobe = adcDataValid & ~adcDataValidQ, where adcDataValidQ is adcDataValid registered.
  - adcData is captured in the strobe cycle.
- Reset values:
  - state=IDLE.
  - procReq=0, procData=0, dacData=0, dacDataValid=0.
  - underrunCount=0, overrunCount=0.
  - gain=0, adcDataValidQ=0, abandoned=0, timer=0.
  - Reset at any point, including mid-handshake, drops procReq on the next cycle with no drain.
- IDLE:
  - On strobe, latch the sample into procData.
  - If bypass=1, latch the dry sample as the result and go to EMIT.
  - Otherwise clear timer and go to REQ.
- REQ:
  - procReq=1.
  - If procAck=1, latch procResult and go to EMIT. Ack wins if it coincides with timeout.
  - Else if timer==timeout, latch the dry sample, set abandoned=1, increment underrunCount and go to EMIT.
  - Else increment timer.
  - The first REQ cycle has timer=0, so at most timeout+1 cycles are spent in REQ.
- EMIT (one cycle):
  - Register dacData = (result * gain) >>> GainShift. The product uses full width; the shift is arithmetic, i.e. a floor toward negative infinity.
  - Gain is unsigned, GainShift+1 bits wide. At unity gain the output equals the result exactly; no saturation is needed.
  - dacDataValid=1 in the following cycle.
  - Update gain after use: if muteReq=1 and gain>0, gain-1; if muteReq=0 and gain<2^GainShift, gain+1. Otherwise hold.
  - Next state is DRAIN if abandoned=1, else IDLE.
- DRAIN:
  - Hold procReq=1 with procData unchanged until procAck.
  - Discard procResult, clear abandoned and go to IDLE.
- Overrun:
  - A strobe while state is not IDLE increments overrunCount.
  - That sample is discarded: no request and no DAC pulse.
  - The previous DAC value persists downstream.
- Latency:
  - Bypass: strobe at cycle T gives dacDataValid at T+2.
  - Engine path: ack at cycle A gives dacDataValid at A+2.
- Counters saturate at 255 and never wrap.
- procReq deasserts in the cycle after the ack cycle.
- Changing bypass or timeout mid-frame affects only the next strobe.

Test Plan:
1. Reset, muteReq=0, bypass=1; run 16 frames to reach unity, then send adcData=0x123 → dacData=0x123 with dacDataValid exactly 2 cycles after the strobe; procReq stays 0.
2. At unity gain, bypass=0, engine acks 3 cycles after procReq with procResult=0x7FF → procData=sample while requesting, dacData=0x7FF at ack+2, underrunCount=0.
3. timeout=8, engine acks only after 20 request cycles:
   - dry sample is emitted after 9 REQ cycles and underrunCount=1;
   - procReq stays high until the ack, the late result is discarded, and busy falls after the ack.
4. Ramp from reset, bypass=1, input -2048 every frame → dacData sequence 0, -128, -256, …, -1920, then -2048 from the 17th frame. Check floor behaviour: input -5 at gain 1 → -1; input 5 at gain 1 → 0.
5. Second strobe during REQ → overrunCount=1, no extra procReq and only one dacDataValid pulse. Also drive 300 overruns → overrunCount=255.
6. Assert reset in the middle of REQ → procReq=0 on the next cycle, all counters 0, gain=0; the next strobe is processed normally.
